// File: rtl/hdr_lsu_mc_if.sv
// Bundle of the requester, response and memory-port signals of the multi-channel
// header LSU. The slave modport is the LSU's view; the master modport is the view
// of the environment (requesters plus memory subsystem) that drives it.
interface hdr_lsu_mc_if #(
  parameter int DATA_W = 64,
  parameter int N_CH   = 2
);
  logic [N_CH-1:0]        req_val_i;
  logic [N_CH-1:0]        req_rdy_o;
  logic [2*N_CH-1:0]      req_op_i;
  logic [DATA_W*N_CH-1:0] req_addr_i;
  logic [DATA_W*N_CH-1:0] req_size_i;
  logic [DATA_W*N_CH-1:0] req_next_i;

  logic [N_CH-1:0]        rsp_val_o;
  logic [N_CH-1:0]        rsp_rdy_i;
  logic [DATA_W-1:0]      rsp_addr_o;
  logic [DATA_W-1:0]      rsp_size_o;
  logic [DATA_W-1:0]      rsp_next_o;
  logic                   rsp_err_o;

  logic                   mem_req_val_o;
  logic                   mem_req_rdy_i;
  logic                   mem_req_is_write_o;
  logic [DATA_W-1:0]      mem_req_addr_o;
  logic [DATA_W-1:0]      mem_req_data_o;
  logic                   mem_rsp_val_i;
  logic                   mem_rsp_rdy_o;
  logic [DATA_W-1:0]      mem_rsp_data_i;

  modport slave (
    input  req_val_i, req_op_i, req_addr_i, req_size_i, req_next_i,
    output req_rdy_o,
    output rsp_val_o, rsp_addr_o, rsp_size_o, rsp_next_o, rsp_err_o,
    input  rsp_rdy_i,
    output mem_req_val_o, mem_req_is_write_o, mem_req_addr_o, mem_req_data_o,
    input  mem_req_rdy_i,
    input  mem_rsp_val_i, mem_rsp_data_i,
    output mem_rsp_rdy_o
  );

  modport master (
    output req_val_i, req_op_i, req_addr_i, req_size_i, req_next_i,
    input  req_rdy_o,
    input  rsp_val_o, rsp_addr_o, rsp_size_o, rsp_next_o, rsp_err_o,
    output rsp_rdy_i,
    input  mem_req_val_o, mem_req_is_write_o, mem_req_addr_o, mem_req_data_o,
    output mem_req_rdy_i,
    output mem_rsp_val_i, mem_rsp_data_i,
    input  mem_rsp_rdy_o
  );
endinterface

// File: rtl/hdr_lsu_mc.sv
// Multi-channel free-list header LSU. A round-robin arbiter picks one requester
// per idle cycle; the operation is then serialised into one or two word accesses
// (size word at addr, next_addr word at addr+WORD_BYTES) on a single memory port,
// and the header is returned to the granted channel.
// Optional build macro: HDR_LSU_ALIGN_CHECK_EN -- when defined, a request whose
// address is not word aligned is rejected with rsp_err_o without touching memory.
module hdr_lsu_mc #(
  parameter int DATA_W     = 64,
  parameter int N_CH       = 2,
  parameter int WORD_BYTES = DATA_W / 8
) (
  input logic            clk_i,
  input logic            rst_i,
  hdr_lsu_mc_if.slave    bus
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [1:0] OP_LOAD       = 2'd0;
  localparam logic [1:0] OP_STORE_NEXT = 2'd2;
  localparam logic [1:0] OP_RSVD       = 2'd3;

  localparam logic [DATA_W-1:0] WORD_OFS = DATA_W'(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    W0_REQ,
    W0_RSP,
    W1_REQ,
    W1_RSP,
    CORE_RSP
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  gnt_q, gnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] size_q, size_d;
  logic [DATA_W-1:0] next_q, next_d;
  logic              err_q, err_d;

  logic              arb_found;
  logic [PTR_W-1:0]  arb_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_size;
  logic [DATA_W-1:0] sel_next;
  logic              rsp_rdy_sel;
  logic              misaligned;

  // Round-robin scan: first requesting channel at or above the pointer, with wrap.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N_CH; i++) begin
      scan_idx = PTR_W'((int'(ptr_q) + i) % N_CH);
      if (!arb_found && bus.req_val_i[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  // Mux the candidate's payload and the owner's response-ready out of the flat buses.
  always_comb begin
    sel_op      = '0;
    sel_addr    = '0;
    sel_size    = '0;
    sel_next    = '0;
    rsp_rdy_sel = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (arb_idx == PTR_W'(c)) begin
        sel_op   = bus.req_op_i[2*c +: 2];
        sel_addr = bus.req_addr_i[DATA_W*c +: DATA_W];
        sel_size = bus.req_size_i[DATA_W*c +: DATA_W];
        sel_next = bus.req_next_i[DATA_W*c +: DATA_W];
      end
      if (gnt_q == PTR_W'(c)) begin
        rsp_rdy_sel = bus.rsp_rdy_i[c];
      end
    end
  end

`ifdef HDR_LSU_ALIGN_CHECK_EN
  localparam logic [DATA_W-1:0] ALIGN_MASK = DATA_W'(WORD_BYTES - 1);
  assign misaligned = (sel_addr & ALIGN_MASK) != '0;
`else
  assign misaligned = 1'b0;
`endif

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one word per REQ/RSP pair, STORE_NEXT skips the size word.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          if (sel_op == OP_RSVD || misaligned) state_d = CORE_RSP;
          else if (sel_op == OP_STORE_NEXT)    state_d = W1_REQ;
          else                                 state_d = W0_REQ;
        end
      end
      W0_REQ:   if (bus.mem_req_rdy_i) state_d = W0_RSP;
      W0_RSP:   if (bus.mem_rsp_val_i) state_d = W1_REQ;
      W1_REQ:   if (bus.mem_req_rdy_i) state_d = W1_RSP;
      W1_RSP:   if (bus.mem_rsp_val_i) state_d = CORE_RSP;
      CORE_RSP: if (rsp_rdy_sel)       state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the current state so each bus is quiet outside its phase.
  always_comb begin
    bus.req_rdy_o          = '0;
    bus.rsp_val_o          = '0;
    bus.rsp_addr_o         = '0;
    bus.rsp_size_o         = '0;
    bus.rsp_next_o         = '0;
    bus.rsp_err_o          = 1'b0;
    bus.mem_req_val_o      = 1'b0;
    bus.mem_req_is_write_o = 1'b0;
    bus.mem_req_addr_o     = '0;
    bus.mem_req_data_o     = '0;
    bus.mem_rsp_rdy_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        for (int c = 0; c < N_CH; c++) begin
          if (arb_found && arb_idx == PTR_W'(c)) bus.req_rdy_o[c] = 1'b1;
        end
      end
      W0_REQ: begin
        bus.mem_req_val_o      = 1'b1;
        bus.mem_req_is_write_o = (op_q != OP_LOAD);
        bus.mem_req_addr_o     = addr_q;
        bus.mem_req_data_o     = (op_q != OP_LOAD) ? size_q : '0;
      end
      W1_REQ: begin
        bus.mem_req_val_o      = 1'b1;
        bus.mem_req_is_write_o = (op_q != OP_LOAD);
        bus.mem_req_addr_o     = addr_q + WORD_OFS;
        bus.mem_req_data_o     = (op_q != OP_LOAD) ? next_q : '0;
      end
      W0_RSP, W1_RSP: begin
        bus.mem_rsp_rdy_o = 1'b1;
      end
      CORE_RSP: begin
        for (int c = 0; c < N_CH; c++) begin
          if (gnt_q == PTR_W'(c)) bus.rsp_val_o[c] = 1'b1;
        end
        bus.rsp_addr_o = addr_q;
        bus.rsp_size_o = size_q;
        bus.rsp_next_o = next_q;
        bus.rsp_err_o  = err_q;
      end
      default: ;
    endcase
  end

  // Header capture at grant, and load data capture as each word returns.
  always_comb begin
    ptr_d  = ptr_q;
    gnt_d  = gnt_q;
    op_d   = op_q;
    addr_d = addr_q;
    size_d = size_q;
    next_d = next_q;
    err_d  = err_q;
    if (state_q == IDLE && arb_found) begin
      ptr_d  = (arb_idx == PTR_W'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
      gnt_d  = arb_idx;
      op_d   = sel_op;
      addr_d = sel_addr;
      size_d = sel_size;
      next_d = sel_next;
      err_d  = (sel_op == OP_RSVD) || misaligned;
    end
    if (bus.mem_rsp_val_i && op_q == OP_LOAD) begin
      if (state_q == W0_RSP) size_d = bus.mem_rsp_data_i;
      if (state_q == W1_RSP) next_d = bus.mem_rsp_data_i;
    end
  end

  // Datapath registers: pointer restarts at channel 0 and the header clears on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      op_q   <= '0;
      addr_q <= '0;
      size_q <= '0;
      next_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      op_q   <= op_d;
      addr_q <= addr_d;
      size_q <= size_d;
      next_q <= next_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_hdr_lsu_mc.sv
// Directed bench for hdr_lsu_mc: two channels in front of a zero-wait memory
// model that logs every accepted access. Honours HDR_LSU_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module tb_hdr_lsu_mc;

  localparam int DATA_W = 64;
  localparam int N_CH   = 2;

  localparam logic [1:0] LOAD       = 2'd0;
  localparam logic [1:0] STORE      = 2'd1;
  localparam logic [1:0] STORE_NEXT = 2'd2;
  localparam logic [1:0] RSVD       = 2'd3;

  logic clk;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  hdr_lsu_mc_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus ();

  hdr_lsu_mc #(.DATA_W(DATA_W), .N_CH(N_CH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic        is_write;
    logic [63:0] addr;
    logic [63:0] data;
  } mem_txn_t;

  mem_txn_t    mem_log[$];
  logic [63:0] mem_arr [logic [63:0]];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: accepts on handshake, answers one cycle later, reset with the LSU.
  always @(posedge clk) begin
    if (rst) begin
      bus.mem_rsp_val_i  <= 1'b0;
      bus.mem_rsp_data_i <= '0;
    end else begin
      bus.mem_rsp_val_i <= 1'b0;
      if (bus.mem_req_val_o && bus.mem_req_rdy_i) begin
        mem_log.push_back({bus.mem_req_is_write_o, bus.mem_req_addr_o, bus.mem_req_data_o});
        bus.mem_rsp_val_i <= 1'b1;
        if (bus.mem_req_is_write_o) begin
          mem_arr[bus.mem_req_addr_o] = bus.mem_req_data_o;
          bus.mem_rsp_data_i <= '0;
        end else begin
          bus.mem_rsp_data_i <= mem_arr.exists(bus.mem_req_addr_o) ? mem_arr[bus.mem_req_addr_o] : 64'h0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present a request on one channel, wait for its grant, then withdraw it.
  task automatic applyStimulus(input int ch, input logic [1:0] op, input logic [63:0] addr,
                               input logic [63:0] size, input logic [63:0] nxt);
    logic granted;
    granted = 1'b0;
    bus.req_op_i[2*ch +: 2]           = op;
    bus.req_addr_i[DATA_W*ch +: DATA_W] = addr;
    bus.req_size_i[DATA_W*ch +: DATA_W] = size;
    bus.req_next_i[DATA_W*ch +: DATA_W] = nxt;
    bus.req_val_i[ch]                 = 1'b1;
    #1;
    for (int k = 0; k < 50; k++) begin
      if (bus.req_rdy_o[ch]) begin
        granted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("grant.ch%0d", ch), 64'(granted), 64'd1);
    @(negedge clk);
    bus.req_val_i[ch] = 1'b0;
  endtask

  // Count negedges until the channel's response is valid (grant cycle counts as 1).
  task automatic waitRsp(input int ch, output int cycles);
    cycles = 1;
    while (!bus.rsp_val_o[ch] && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Check the response fields, complete the handshake, and confirm it drops.
  task automatic checkRsp(input string tag, input int ch, input logic [63:0] addr,
                          input logic [63:0] size, input logic [63:0] nxt, input logic err);
    checkOutput({tag, ".val"},  64'(bus.rsp_val_o), 64'(1) << ch);
    checkOutput({tag, ".addr"}, bus.rsp_addr_o, addr);
    checkOutput({tag, ".size"}, bus.rsp_size_o, size);
    checkOutput({tag, ".next"}, bus.rsp_next_o, nxt);
    checkOutput({tag, ".err"},  64'(bus.rsp_err_o), 64'(err));
    bus.rsp_rdy_i[ch] = 1'b1;
    @(negedge clk);
    bus.rsp_rdy_i[ch] = 1'b0;
    checkOutput({tag, ".drop"}, 64'(bus.rsp_val_o), 64'd0);
  endtask

  task automatic checkMem(input string tag, input int idx, input logic is_write,
                          input logic [63:0] addr, input logic [63:0] data, input logic with_data);
    if (idx < mem_log.size()) begin
      checkOutput({tag, ".we"},   64'(mem_log[idx].is_write), 64'(is_write));
      checkOutput({tag, ".addr"}, mem_log[idx].addr, addr);
      if (with_data) checkOutput({tag, ".data"}, mem_log[idx].data, data);
    end else begin
      checkOutput({tag, ".present"}, 64'(mem_log.size()), 64'(idx + 1));
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".req_rdy"},   64'(bus.req_rdy_o), 64'd0);
    checkOutput({tag, ".rsp_val"},   64'(bus.rsp_val_o), 64'd0);
    checkOutput({tag, ".rsp_err"},   64'(bus.rsp_err_o), 64'd0);
    checkOutput({tag, ".rsp_size"},  bus.rsp_size_o, 64'd0);
    checkOutput({tag, ".mem_val"},   64'(bus.mem_req_val_o), 64'd0);
    checkOutput({tag, ".mem_addr"},  bus.mem_req_addr_o, 64'd0);
    checkOutput({tag, ".mem_rsp_rdy"}, 64'(bus.mem_rsp_rdy_o), 64'd0);
  endtask

  // Directed sequence.
  initial begin
    int lat;
    int waited;
    int exp_ch;

    rst               = 1'b1;
    bus.req_val_i     = '0;
    bus.req_op_i      = '0;
    bus.req_addr_i    = '0;
    bus.req_size_i    = '0;
    bus.req_next_i    = '0;
    bus.rsp_rdy_i     = '0;
    bus.mem_req_rdy_i = 1'b1;
    mem_arr[64'h100]  = 64'h40;
    mem_arr[64'h108]  = 64'h200;
    mem_arr[64'h104]  = 64'h77;
    mem_arr[64'h10c]  = 64'h99;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] LOAD ch0 0x100");
    mem_log.delete();
    applyStimulus(0, LOAD, 64'h100, 64'h0, 64'h0);
    waitRsp(0, lat);
    checkOutput("load.latency", 64'(lat), 64'd5);
    checkRsp("load", 0, 64'h100, 64'h40, 64'h200, 1'b0);
    checkOutput("load.nmem", 64'(mem_log.size()), 64'd2);
    checkMem("load.m0", 0, 1'b0, 64'h100, 64'h0, 1'b0);
    checkMem("load.m1", 1, 1'b0, 64'h108, 64'h0, 1'b0);

    $display("[TB] STORE ch1 0x80");
    mem_log.delete();
    applyStimulus(1, STORE, 64'h80, 64'h20, 64'h300);
    waitRsp(1, lat);
    checkOutput("store.latency", 64'(lat), 64'd5);
    checkRsp("store", 1, 64'h80, 64'h20, 64'h300, 1'b0);
    checkOutput("store.nmem", 64'(mem_log.size()), 64'd2);
    checkMem("store.m0", 0, 1'b1, 64'h80, 64'h20, 1'b1);
    checkMem("store.m1", 1, 1'b1, 64'h88, 64'h300, 1'b1);

    $display("[TB] STORE_NEXT ch0 0x10");
    mem_log.delete();
    applyStimulus(0, STORE_NEXT, 64'h10, 64'h55, 64'h0);
    waitRsp(0, lat);
    checkOutput("stnext.latency", 64'(lat), 64'd3);
    checkRsp("stnext", 0, 64'h10, 64'h55, 64'h0, 1'b0);
    checkOutput("stnext.nmem", 64'(mem_log.size()), 64'd1);
    checkMem("stnext.m0", 0, 1'b1, 64'h18, 64'h0, 1'b1);

    $display("[TB] reserved op ch1");
    mem_log.delete();
    applyStimulus(1, RSVD, 64'h40, 64'h5, 64'h6);
    waitRsp(1, lat);
    checkOutput("rsvd.latency", 64'(lat), 64'd1);
    checkRsp("rsvd", 1, 64'h40, 64'h5, 64'h6, 1'b1);
    checkOutput("rsvd.nmem", 64'(mem_log.size()), 64'd0);

    $display("[TB] misaligned LOAD ch1 0x104");
    mem_log.delete();
    applyStimulus(1, LOAD, 64'h104, 64'h0, 64'h0);
    waitRsp(1, lat);
`ifdef HDR_LSU_ALIGN_CHECK_EN
    checkOutput("align.latency", 64'(lat), 64'd1);
    checkRsp("align", 1, 64'h104, 64'h0, 64'h0, 1'b1);
    checkOutput("align.nmem", 64'(mem_log.size()), 64'd0);
`else
    checkOutput("align.latency", 64'(lat), 64'd5);
    checkRsp("align", 1, 64'h104, 64'h77, 64'h99, 1'b0);
    checkOutput("align.nmem", 64'(mem_log.size()), 64'd2);
    checkMem("align.m0", 0, 1'b0, 64'h104, 64'h0, 1'b0);
    checkMem("align.m1", 1, 1'b0, 64'h10c, 64'h0, 1'b0);
`endif

    $display("[TB] contention, two channels, four operations");
    bus.req_op_i                 = {STORE, STORE};
    bus.req_addr_i[63:0]         = 64'h200;
    bus.req_addr_i[127:64]       = 64'h300;
    bus.req_size_i[63:0]         = 64'h1;
    bus.req_size_i[127:64]       = 64'h3;
    bus.req_next_i[63:0]         = 64'h2;
    bus.req_next_i[127:64]       = 64'h4;
    bus.mem_req_rdy_i            = 1'b0;
    bus.req_val_i                = 2'b11;
    #1;
    for (int n = 0; n < 4; n++) begin
      exp_ch = n % 2;
      waited = 0;
      while (bus.req_rdy_o == '0 && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      checkOutput($sformatf("arb.grant%0d", n), 64'(bus.req_rdy_o), 64'(1) << exp_ch);
      @(negedge clk);
      if (n >= 2) bus.req_val_i[exp_ch] = 1'b0;
      if (n == 0) begin
        for (int s = 0; s < 3; s++) begin
          checkOutput($sformatf("stall%0d.val", s),  64'(bus.mem_req_val_o), 64'd1);
          checkOutput($sformatf("stall%0d.addr", s), bus.mem_req_addr_o, 64'h200);
          checkOutput($sformatf("stall%0d.data", s), bus.mem_req_data_o, 64'h1);
          checkOutput($sformatf("stall%0d.we", s),   64'(bus.mem_req_is_write_o), 64'd1);
          if (s < 2) @(negedge clk);
        end
        bus.mem_req_rdy_i = 1'b1;
      end
      waitRsp(exp_ch, lat);
      if (exp_ch == 0) checkRsp($sformatf("arb.rsp%0d", n), 0, 64'h200, 64'h1, 64'h2, 1'b0);
      else             checkRsp($sformatf("arb.rsp%0d", n), 1, 64'h300, 64'h3, 64'h4, 1'b0);
    end
    bus.req_val_i = '0;
    @(negedge clk);

    $display("[TB] reset during W0_RSP");
    mem_log.delete();
    applyStimulus(0, LOAD, 64'h100, 64'h0, 64'h0);
    @(negedge clk);
    checkOutput("midrst.in_w0rsp", 64'(bus.mem_rsp_rdy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkIdleOutputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    mem_log.delete();
    applyStimulus(0, LOAD, 64'h100, 64'h0, 64'h0);
    waitRsp(0, lat);
    checkOutput("postrst.latency", 64'(lat), 64'd5);
    checkRsp("postrst", 0, 64'h100, 64'h40, 64'h200, 1'b0);
    checkOutput("postrst.nmem", 64'(mem_log.size()), 64'd2);
    checkMem("postrst.m0", 0, 1'b0, 64'h100, 64'h0, 1'b0);
    checkMem("postrst.m1", 1, 1'b0, 64'h108, 64'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hdr_lsu_mc.md
Name: hdr_lsu_mc

Overview:
- Multi-channel successor to the single-port header LSU used by the falafel allocator core.
- Accepts free-list header operations from N_CH independent requesters through a round-robin arbiter.
- Serialises each operation into one or two word accesses on a single shared memory port.
- Returns the header {addr, size, next_addr} to the requesting channel with a per-channel valid/ready handshake.

Parameters:
- DATA_W, 64, width of addresses and header words
- N_CH, 2, number of requester channels (1..8)
- WORD_BYTES, DATA_W/8, byte offset between the size word (at addr) and the next_addr word (at addr+WORD_BYTES)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_val_i  in  N_CH  per-channel request valid
- req_rdy_o  out  N_CH  per-channel request accepted
- req_op_i  in  2*N_CH  op per channel: 0 LOAD, 1 STORE, 2 STORE_NEXT, 3 reserved
- req_addr_i  in  DATA_W*N_CH  header base address
- req_size_i  in  DATA_W*N_CH  size word to store
- req_next_i  in  DATA_W*N_CH  next_addr word to store
- rsp_val_o  out  N_CH  per-channel response valid
- rsp_rdy_i  in  N_CH  per-channel response ready
- rsp_addr_o  out  DATA_W  header addr (shared bus; qualified by rsp_val_o)
- rsp_size_o  out  DATA_W  header size
- rsp_next_o  out  DATA_W  header next_addr
- rsp_err_o  out  1  operation rejected
- mem_req_val_o  out  1  memory request valid
- mem_req_rdy_i  in  1  memory ready
- mem_req_is_write_o  out  1  1 = write
- mem_req_addr_o  out  DATA_W  word address
- mem_req_data_o  out  DATA_W  write data
- mem_rsp_val_i  in  1  memory response valid (reads return data; writes return ack)
- mem_rsp_rdy_o  out  1  LSU accepts memory response
- mem_rsp_data_i  in  DATA_W  read data

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer = channel 0; captured header registers 0.
- FSM states: IDLE, W0_REQ, W0_RSP, W1_REQ, W1_RSP, CORE_RSP.
- IDLE:
  - Grant the first channel with req_val_i set, scanning from the pointer upward with wrap.
  - req_rdy_o[g] is high for exactly one cycle; capture op, addr, size, next.
  - Pointer <= g+1 mod N_CH.
  - Next state: W0_REQ, or W1_REQ for STORE_NEXT, or CORE_RSP with err=1 for op 3.
  - req_rdy_o is 0 in every other state.
- Word 0 (size) is accessed at addr; word 1 (next_addr) at addr+WORD_BYTES. Address addition is DATA_W wide and wraps modulo 2^DATA_W.
- W0_REQ / W1_REQ:
  - mem_req_val_o=1 with addr, data and is_write held stable until mem_req_rdy_i.
  - Is_write = (op != LOAD).
  - On handshake, go to the matching _RSP state.
- W0_RSP / W1_RSP:
  - mem_rsp_rdy_o=1.
  - On mem_rsp_val_i: for LOAD, latch mem_rsp_data_i into size or next.
  - W0_RSP goes to W1_REQ; W1_RSP goes to CORE_RSP.
- At most one memory transaction outstanding. A mem_rsp_val_i arriving outside an _RSP state is ignored (mem_rsp_rdy_o=0).
- CORE_RSP:
  - rsp_val_o[g]=1; rsp_* drive the captured addr/size/next and err.
  - For STORE/STORE_NEXT the response echoes the stored values.
  - Hold until rsp_rdy_i[g], then return to IDLE.
  - A new grant may occur no earlier than the cycle after the response handshake.
- Latency with an always-ready zero-wait memory:
  - LOAD/STORE: accept at T, mem req T+1, mem rsp T+2, req T+3, rsp T+4, rsp_val_o at T+5.
  - STORE_NEXT: rsp_val_o at T+3.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester not granted keeps req_val_i high with stable payload.
- Reset mid-operation: abort immediately to IDLE. Any in-flight memory transaction is abandoned. The memory subsystem is reset by the same rst_i.
- N_CH=1: the arbiter degenerates to channel 0 always.

Optional Feature:
- Macro: HDR_LSU_ALIGN_CHECK_EN.
- Defined: at grant, if addr[$clog2(WORD_BYTES)-1:0] != 0, skip memory and go directly to CORE_RSP with rsp_err_o=1.
- Not defined: no check; misaligned addresses go to memory unchanged.

Test Plan:
- LOAD ch0 addr=0x100; memory returns 0x40 then 0x200 -> mem reads at 0x100, 0x108; rsp_val_o[0] with size=0x40, next=0x200, err=0, at T+5.
- STORE ch1 addr=0x80 size=0x20 next=0x300 -> writes (0x80, 0x20) then (0x88, 0x300); response echoes the values.
- STORE_NEXT ch0 addr=0x10 next=0x0 -> single write (0x18, 0x0); response at T+3.
- Both channels request continuously for 4 operations -> grants 0,1,0,1. Hold mem_req_rdy_i low 3 cycles -> request fields stay stable.
- op=3 -> no memory traffic, err=1. With HDR_LSU_ALIGN_CHECK_EN, addr=0x104 -> no memory traffic, err=1.
- rst_i asserted in W0_RSP -> next cycle all outputs 0, FSM IDLE; a following LOAD completes normally.
